// File: rtl/router_pkg.sv
// Shared flit type encoding and arbiter state definitions for the readout router.
package router_pkg;

    localparam int unsigned FLIT_TYPE_MSB_OFS = 1;  // type field sits at [FLIT_W-1 : FLIT_W-2]
    localparam int unsigned FLIT_TYPE_LSB_OFS = 2;
    localparam int unsigned FLIT_MAX_W        = 64;
    localparam int unsigned FLIT_IDX_W        = 6;

    typedef enum logic [1:0] {
        FT_BODY   = 2'b00,
        FT_TAIL   = 2'b01,
        FT_HEAD   = 2'b10,
        FT_SINGLE = 2'b11
    } flit_type_e;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Callers zero-extend their flit to FLIT_MAX_W and pass their real width.
    function automatic flit_type_e get_flit_type(input logic [FLIT_MAX_W-1:0] flit,
                                                 input int unsigned           flit_w);
        logic [FLIT_IDX_W-1:0] msb;
        logic [FLIT_IDX_W-1:0] lsb;
        msb = FLIT_IDX_W'(flit_w - FLIT_TYPE_MSB_OFS);
        lsb = FLIT_IDX_W'(flit_w - FLIT_TYPE_LSB_OFS);
        return flit_type_e'({flit[msb], flit[lsb]});
    endfunction

endpackage

// File: rtl/router_flit_arb_mux_fifo.sv
// Per-channel synchronous show-ahead FIFO; one extra pointer bit separates full from empty.
module router_flit_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign dout  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push && !full) begin
            mem_d[wr_ptr_q[AW-1:0]] = din;
            wr_ptr_d                = wr_ptr_q + PW'(1);
        end
        if (pop && !empty) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: pointers alone define validity.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/router_flit_arb_mux.sv
// N-channel flit concentrator: per-channel FIFOs, round-robin arbiter with optional
// head-to-tail packet lock, and a registered valid/ready output stage.
module router_flit_arb_mux
    import router_pkg::*;
#(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned FLIT_W     = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned PKT_MODE   = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH*FLIT_W-1:0]  in_flit_i,
    input  logic [NUM_CH-1:0]         in_vld_i,
    output logic [NUM_CH-1:0]         in_rdy_o,
    output logic [FLIT_W-1:0]         out_flit_o,
    output logic                      out_vld_o,
    input  logic                      out_rdy_i,
    output logic [$clog2(NUM_CH)-1:0] src_ch_o,
    output logic                      err_o
);
    localparam int unsigned CH_W = $clog2(NUM_CH);
    localparam int unsigned RR_W = CH_W + 1;

    logic [NUM_CH-1:0] fifo_full, fifo_empty, fifo_push, fifo_pop, eligible;
    logic [FLIT_W-1:0] fifo_dout [NUM_CH];

    arb_state_e        state_q, state_d;
    logic [CH_W-1:0]   lock_ch_q, lock_ch_d;
    logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic              out_vld_q, out_vld_d;
    logic [FLIT_W-1:0] out_flit_q, out_flit_d;
    logic [CH_W-1:0]   src_ch_q, src_ch_d;
    logic              err_q, err_d;

    logic              grant_vld;
    logic [CH_W-1:0]   grant_ch;
    logic [RR_W-1:0]   rr_idx;
    flit_type_e        grant_type;
    logic              out_load;

    assign in_rdy_o  = rst ? ~fifo_full : '0;
    assign fifo_push = in_vld_i & in_rdy_o;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_fifo
        router_flit_fifo #(
            .WIDTH (FLIT_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (fifo_push[c]),
            .pop   (fifo_pop[c]),
            .din   (in_flit_i[c*FLIT_W +: FLIT_W]),
            .dout  (fifo_dout[c]),
            .full  (fifo_full[c]),
            .empty (fifo_empty[c])
        );
    end

    // While locked only the owning channel may compete.
    always_comb begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            eligible[c] = !fifo_empty[c] && (state_q == ARB_IDLE || lock_ch_q == CH_W'(c));
        end
    end

    // Round-robin search starting at rr_ptr_q, first eligible channel wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_ch  = '0;
        rr_idx    = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            rr_idx = RR_W'(rr_ptr_q) + RR_W'(i);
            if (rr_idx >= RR_W'(NUM_CH)) begin
                rr_idx = rr_idx - RR_W'(NUM_CH);
            end
            if (!grant_vld && eligible[rr_idx[CH_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_ch  = rr_idx[CH_W-1:0];
            end
        end
        grant_type = get_flit_type(FLIT_MAX_W'(fifo_dout[grant_ch]), FLIT_W);
    end

    always_comb begin
        state_d    = state_q;
        lock_ch_d  = lock_ch_q;
        rr_ptr_d   = rr_ptr_q;
        out_vld_d  = out_vld_q;
        out_flit_d = out_flit_q;
        src_ch_d   = src_ch_q;
        err_d      = err_q;
        fifo_pop   = '0;
        out_load   = !out_vld_q || out_rdy_i;
        if (out_load) begin
            out_vld_d = grant_vld;
            if (grant_vld) begin
                fifo_pop   = NUM_CH'(1) << grant_ch;
                out_flit_d = fifo_dout[grant_ch];
                src_ch_d   = grant_ch;
                rr_ptr_d   = (grant_ch == CH_W'(NUM_CH - 1)) ? '0 : grant_ch + CH_W'(1);
                if (PKT_MODE != 0) begin
                    case (state_q)
                        ARB_IDLE: begin
                            if (grant_type == FT_HEAD) begin
                                state_d   = ARB_LOCKED;
                                lock_ch_d = grant_ch;
                            end else if (grant_type == FT_BODY || grant_type == FT_TAIL) begin
                                err_d = 1'b1;
                            end
                        end
                        ARB_LOCKED: begin
                            // A repeated head means the previous tail went missing.
                            if (grant_type == FT_TAIL) begin
                                state_d = ARB_IDLE;
                            end else if (grant_type == FT_HEAD) begin
                                err_d = 1'b1;
                            end
                        end
                        default: state_d = ARB_IDLE;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ARB_IDLE;
            lock_ch_q  <= '0;
            rr_ptr_q   <= '0;
            out_vld_q  <= 1'b0;
            out_flit_q <= '0;
            src_ch_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_ch_q  <= lock_ch_d;
            rr_ptr_q   <= rr_ptr_d;
            out_vld_q  <= out_vld_d;
            out_flit_q <= out_flit_d;
            src_ch_q   <= src_ch_d;
            err_q      <= err_d;
        end
    end

    assign out_vld_o  = out_vld_q;
    assign out_flit_o = out_flit_q;
    assign src_ch_o   = src_ch_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_router_flit_arb_mux.sv
// Bench for router_flit_arb_mux: a packet-mode and a flit-mode instance, each checked every
// cycle against a queue-based reference model, plus directed literal checks.
module tb_router_flit_arb_mux;
    localparam int unsigned NUM_CH = 4;
    localparam int unsigned FLIT_W = 32;
    localparam int unsigned DEPTH  = 4;
    localparam logic [31:0] LOCK_SEQ [7] = '{32'h8000_0001, 32'h0000_0002, 32'h0000_0003,
                                             32'h4000_0004, 32'hC000_0010, 32'hC000_0011,
                                             32'hC000_0012};

    logic clk = 1'b0;
    logic rst;
    logic [1:0][NUM_CH*FLIT_W-1:0] in_flit;
    logic [1:0][NUM_CH-1:0]        in_vld;
    logic [1:0][NUM_CH-1:0]        in_rdy;
    logic [1:0][FLIT_W-1:0]        out_flit;
    logic [1:0]                    out_vld;
    logic [1:0]                    out_rdy;
    logic [1:0]                    err;
    logic [1:0][1:0]               src_ch;

    always #5 clk = ~clk;

    router_flit_arb_mux #(.NUM_CH(NUM_CH), .FLIT_W(FLIT_W), .FIFO_DEPTH(DEPTH), .PKT_MODE(1)) u_pkt (
        .clk(clk), .rst(rst), .in_flit_i(in_flit[0]), .in_vld_i(in_vld[0]), .in_rdy_o(in_rdy[0]),
        .out_flit_o(out_flit[0]), .out_vld_o(out_vld[0]), .out_rdy_i(out_rdy[0]),
        .src_ch_o(src_ch[0]), .err_o(err[0]));

    router_flit_arb_mux #(.NUM_CH(NUM_CH), .FLIT_W(FLIT_W), .FIFO_DEPTH(DEPTH), .PKT_MODE(0)) u_flit (
        .clk(clk), .rst(rst), .in_flit_i(in_flit[1]), .in_vld_i(in_vld[1]), .in_rdy_o(in_rdy[1]),
        .out_flit_o(out_flit[1]), .out_vld_o(out_vld[1]), .out_rdy_i(out_rdy[1]),
        .src_ch_o(src_ch[1]), .err_o(err[1]));

    // Per-instance sources (flits still to offer) and model FIFO contents.
    logic [31:0] srcq [2][NUM_CH][$];
    logic [31:0] mq   [2][NUM_CH][$];
    logic        m_vld  [2];
    logic [31:0] m_flit [2];
    int          m_src  [2];
    logic        m_err  [2];
    int          m_rr   [2];
    logic        m_lock [2];
    int          m_lock_ch [2];
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                in_vld[i][c] = (srcq[i][c].size() > 0);
                in_flit[i][c*FLIT_W +: FLIT_W] = (srcq[i][c].size() > 0) ? srcq[i][c][0] : 32'h0;
            end
        end
    endtask

    // One clock edge of the reference behaviour, from the values present at the edge.
    task automatic model_step();
        int g;
        int c;
        logic [31:0] f;
        logic [1:0] t;
        logic [NUM_CH-1:0] acc;
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                for (int k = 0; k < NUM_CH; k++) mq[i][k].delete();
                m_vld[i] = 0; m_flit[i] = 0; m_src[i] = 0; m_err[i] = 0;
                m_rr[i] = 0; m_lock[i] = 0; m_lock_ch[i] = 0;
            end else begin
                for (int k = 0; k < NUM_CH; k++) acc[k] = in_vld[i][k] && (mq[i][k].size() < DEPTH);
                if (!m_vld[i] || out_rdy[i]) begin
                    g = -1;
                    for (int k = 0; k < NUM_CH; k++) begin
                        c = (m_rr[i] + k) % NUM_CH;
                        if (g < 0 && mq[i][c].size() > 0 && (!m_lock[i] || c == m_lock_ch[i])) g = c;
                    end
                    m_vld[i] = (g >= 0);
                    if (g >= 0) begin
                        f = mq[i][g].pop_front();
                        m_flit[i] = f;
                        m_src[i] = g;
                        m_rr[i] = (g + 1) % NUM_CH;
                        t = f[31:30];
                        if (i == 0) begin
                            if (!m_lock[i]) begin
                                if (t == 2'b10) begin m_lock[i] = 1; m_lock_ch[i] = g; end
                                else if (t == 2'b00 || t == 2'b01) m_err[i] = 1;
                            end else begin
                                if (t == 2'b01) m_lock[i] = 0;
                                else if (t == 2'b10) m_err[i] = 1;
                            end
                        end
                    end
                end
                for (int k = 0; k < NUM_CH; k++) begin
                    if (acc[k]) mq[i][k].push_back(srcq[i][k].pop_front());
                end
            end
        end
    endtask

    task automatic compare();
        string tag;
        logic [NUM_CH-1:0] exp_rdy;
        for (int i = 0; i < 2; i++) begin
            tag = (i == 0) ? "pkt" : "flit";
            for (int c = 0; c < NUM_CH; c++) exp_rdy[c] = rst && (mq[i][c].size() < DEPTH);
            chk($sformatf("%s.in_rdy", tag), 32'(in_rdy[i]), 32'(exp_rdy));
            chk($sformatf("%s.out_vld", tag), 32'(out_vld[i]), 32'(m_vld[i]));
            chk($sformatf("%s.err", tag), 32'(err[i]), 32'(m_err[i]));
            if (m_vld[i] || !rst) begin
                chk($sformatf("%s.out_flit", tag), out_flit[i], m_flit[i]);
                chk($sformatf("%s.src_ch", tag), 32'(src_ch[i]), 32'(m_src[i]));
            end
        end
    endtask

    task automatic cycle();
        drive();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic reset_dut();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) for (int c = 0; c < NUM_CH; c++) srcq[i][c].delete();
        cycle();
        cycle();
        rst = 1'b1;
    endtask

    function automatic bit idle();
        for (int i = 0; i < 2; i++) begin
            if (m_vld[i]) return 1'b0;
            for (int c = 0; c < NUM_CH; c++)
                if (srcq[i][c].size() != 0 || mq[i][c].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic drain(input int budget);
        int n = 0;
        out_rdy = 2'b11;
        while (!idle() && n < budget) begin
            cycle();
            n++;
        end
        if (!idle()) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: still busy after %0d cycles, required idle", budget);
        end
    endtask

    task automatic gen_pkt(input int i, input int c);
        int len = int'($urandom_range(1, 4));
        if (len == 1) begin
            srcq[i][c].push_back({2'b11, 30'($urandom)});
        end else begin
            srcq[i][c].push_back({2'b10, 30'($urandom)});
            for (int k = 0; k < len - 2; k++) srcq[i][c].push_back({2'b00, 30'($urandom)});
            srcq[i][c].push_back({2'b01, 30'($urandom)});
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got0 [$];
        logic [31:0] got1 [$];
        rst = 1'b0; out_rdy = 2'b11; in_vld = '0; in_flit = '0;

        // Reset held with every channel offering a flit
        for (int i = 0; i < 2; i++)
            for (int c = 0; c < NUM_CH; c++) srcq[i][c].push_back(32'hC000_0001 + 32'(c) * 32'h10);
        repeat (5) begin
            cycle();
            chk("rst.in_rdy", 32'(in_rdy[0]), 32'h0);
            chk("rst.out_vld", 32'(out_vld[0]), 32'h0);
        end
        rst = 1'b1;
        cycle();
        chk("rel.in_rdy_pkt", 32'(in_rdy[0]), 32'hF);
        chk("rel.in_rdy_flit", 32'(in_rdy[1]), 32'hF);
        drain(100);

        // Two-cycle latency then bubble
        for (int i = 0; i < 2; i++) srcq[i][2].push_back(32'hC000_0055);
        cycle();
        chk("lat.early_vld", 32'(out_vld[0]), 32'h0);
        cycle();
        for (int i = 0; i < 2; i++) begin
            chk("lat.vld", 32'(out_vld[i]), 32'h1);
            chk("lat.flit", out_flit[i], 32'hC000_0055);
            chk("lat.src", 32'(src_ch[i]), 32'h2);
        end
        cycle();
        chk("lat.bubble", 32'(out_vld[0]), 32'h0);

        // Round-robin order with all channels loaded
        reset_dut();
        for (int i = 0; i < 2; i++)
            for (int c = 0; c < NUM_CH; c++)
                for (int k = 0; k < 2; k++) srcq[i][c].push_back(32'hC000_0100 + 32'(c) * 32'h10 + 32'(k));
        cycle();
        for (int k = 0; k < 8; k++) begin
            cycle();
            for (int i = 0; i < 2; i++) begin
                chk("rr.vld", 32'(out_vld[i]), 32'h1);
                chk("rr.src", 32'(src_ch[i]), 32'(k % 4));
            end
        end
        drain(50);

        // Packet lock: ch1 packet must not be split by ch0 singles
        for (int i = 0; i < 2; i++) begin
            srcq[i][1].push_back(32'h8000_0001);
            srcq[i][1].push_back(32'h0000_0002);
            srcq[i][1].push_back(32'h0000_0003);
            srcq[i][1].push_back(32'h4000_0004);
        end
        cycle();
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 3; k++) srcq[i][0].push_back(32'hC000_0010 + 32'(k));
        got0.delete();
        repeat (20) begin
            cycle();
            if (out_vld[0]) got0.push_back(out_flit[0]);
        end
        chk("lock.count", 32'(got0.size()), 32'd7);
        for (int k = 0; k < 7; k++)
            if (k < got0.size()) chk($sformatf("lock.seq%0d", k), got0[k], LOCK_SEQ[k]);

        // Backpressure: 1 output register + 4 FIFO entries absorb 5 of 6 flits
        reset_dut();
        out_rdy = 2'b00;
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 6; k++) srcq[i][3].push_back(32'hC000_0100 + 32'(k));
        repeat (8) cycle();
        for (int i = 0; i < 2; i++) begin
            chk("bp.in_rdy", 32'(in_rdy[i]), 32'h7);
            chk("bp.vld", 32'(out_vld[i]), 32'h1);
            chk("bp.flit", out_flit[i], 32'hC000_0100);
        end
        out_rdy = 2'b11;
        got0.delete();
        got1.delete();
        repeat (12) begin
            if (out_vld[0]) got0.push_back(out_flit[0]);
            if (out_vld[1]) got1.push_back(out_flit[1]);
            cycle();
        end
        chk("bp.count_pkt", 32'(got0.size()), 32'd6);
        chk("bp.count_flit", 32'(got1.size()), 32'd6);
        for (int k = 0; k < 6; k++)
            if (k < got0.size()) chk($sformatf("bp.seq%0d", k), got0[k], 32'hC000_0100 + 32'(k));

        // Stray BODY in idle: error only in packet mode, sticky until reset
        reset_dut();
        for (int i = 0; i < 2; i++) srcq[i][0].push_back(32'h0000_00AA);
        cycle();
        cycle();
        chk("err.vld", 32'(out_vld[0]), 32'h1);
        chk("err.flit", out_flit[0], 32'h0000_00AA);
        chk("err.pkt", 32'(err[0]), 32'h1);
        chk("err.flitmode", 32'(err[1]), 32'h0);
        repeat (5) cycle();
        chk("err.sticky", 32'(err[0]), 32'h1);
        rst = 1'b0;
        cycle();
        chk("err.cleared", 32'(err[0]), 32'h0);
        rst = 1'b1;

        // Random well-formed packets with random backpressure and a mid-stream reset
        for (int n = 0; n < 800; n++) begin
            if (n == 400) begin
                rst = 1'b0;
                for (int i = 0; i < 2; i++) for (int c = 0; c < NUM_CH; c++) srcq[i][c].delete();
                cycle();
                rst = 1'b1;
            end
            for (int i = 0; i < 2; i++) out_rdy[i] = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 2; i++)
                for (int c = 0; c < NUM_CH; c++)
                    if (srcq[i][c].size() == 0 && $urandom_range(0, 2) == 0) gen_pkt(i, c);
            cycle();
        end
        drain(300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/router_flit_arb_mux.md
Name: router_flit_arb_mux

Overview:
Parametrised N-channel flit concentrator for the sensor-network readout router. Each input channel has its own valid/ready port and a small input FIFO. A round-robin arbiter merges the channels onto one registered valid/ready output port. Packet mode holds the grant from head flit to tail flit so packets are never interleaved; flit mode arbitrates per flit.

Parameters:
NUM_CH, 4, number of input channels (2..16)
FLIT_W, 32, flit width in bits; bits [FLIT_W-1:FLIT_W-2] carry the flit type
FIFO_DEPTH, 4, per-channel FIFO depth (power of 2, >=2)
PKT_MODE, 1, 1 = grant locked head-to-tail; 0 = per-flit arbitration, type bits ignored

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-low
in_flit_i  input  NUM_CH*FLIT_W  channel c occupies bits [c*FLIT_W +: FLIT_W]
in_vld_i  input  NUM_CH  per-channel valid
in_rdy_o  output  NUM_CH  per-channel ready
out_flit_o  output  FLIT_W  merged flit, registered
out_vld_o  output  1  output valid, registered
out_rdy_i  input  1  downstream ready
src_ch_o  output  $clog2(NUM_CH)  source channel of the current out_flit_o, registered
err_o  output  1  sticky protocol-error flag

Behaviour:
- Flit type field, MSB 2 bits: 2'b10 HEAD, 2'b00 BODY, 2'b01 TAIL, 2'b11 SINGLE.
- Reset (rst==0 at a clock edge):
  - All FIFOs are emptied.
  - out_vld_o=0, out_flit_o=0, src_ch_o=0, err_o=0.
  - rr_ptr=0, so channel 0 has highest priority first.
  - Lock is cleared.
  - in_rdy_o is forced to 0 while rst==0.
  - Reset mid-packet discards all buffered flits and the lock; no partial flit is emitted afterwards.
- Input side:
  - in_rdy_o[c] = !full[c] (combinational from occupancy, not from in_vld_i).
  - A push occurs on an edge where in_vld_i[c] & in_rdy_o[c].
  - A full FIFO never accepts, even if it is popped in the same cycle.
- Output register:
  - Loads on an edge when (!out_vld_o | out_rdy_i) and an eligible channel exists. The loading pops that FIFO and sets src_ch_o.
  - If no channel is eligible while draining, out_vld_o drops to 0 (bubble).
  - While out_vld_o & !out_rdy_i, out_flit_o and src_ch_o hold stable.
- Latency: a flit pushed at edge T into an empty system with out_rdy_i=1 appears with out_vld_o=1 after edge T+1, i.e. 2 cycles. Full throughput is 1 flit/cycle.
- Arbitration:
  - A channel is eligible if its FIFO is non-empty, subject to the lock rule below.
  - Round-robin search starts at rr_ptr. After a grant to channel g, rr_ptr = (g+1) mod NUM_CH.
- Packet locking (PKT_MODE=1) — state machine IDLE/LOCKED:
  - IDLE: round-robin over all channels. A granted HEAD moves to LOCKED(lock_ch=g). SINGLE stays in IDLE.
  - LOCKED: only lock_ch is eligible. An empty lock_ch gives bubbles; other channels wait. Popping a TAIL from lock_ch returns to IDLE.
  - A HEAD arriving while LOCKED on lock_ch (missing tail) is forwarded and keeps the lock; err_o is set.
  - A BODY or TAIL granted in IDLE (no open packet) is forwarded as a single and sets err_o.
- PKT_MODE=0: no lock state, pure per-flit round-robin, err_o held 0.
- err_o is sticky and is cleared only by reset.

Decomposition:
- Package router_pkg:
  - flit_type_e enum (HEAD/BODY/TAIL/SINGLE).
  - FLIT_TYPE_MSB/LSB offset constants.
  - Function get_flit_type(flit).
  - arb_state_e (IDLE/LOCKED).
- Sub-module router_flit_fifo: synchronous FIFO, params WIDTH/DEPTH, ports push/pop/din/dout/full/empty, same clk/rst. Instantiated NUM_CH times in a generate loop.
- Top level holds the arbiter, lock FSM and output register.

Test Plan:
1. Reset: hold rst=0 for 5 cycles with in_vld_i=4'hF -> in_rdy_o=4'h0 and out_vld_o=0 throughout; one cycle after release in_rdy_o=4'hF.
2. Latency: out_rdy_i=1, push SINGLE 32'hC000_0055 on ch2 at edge T -> out_vld_o=1, out_flit_o=32'hC000_0055, src_ch_o=2 after edge T+1; out_vld_o=0 the cycle after.
3. Round-robin: PKT_MODE=0, push 2 flits on every channel simultaneously, out_rdy_i=1 -> src_ch_o sequence 0,1,2,3,0,1,2,3, with no bubbles.
4. Packet lock: ch1 pushes HEAD 32'h8000_0001, BODY 32'h0000_0002, BODY 32'h0000_0003, TAIL 32'h4000_0004 from edge T; ch0 pushes 3 SINGLEs from T+1 -> output is the 4 ch1 flits contiguously, then ch0 x3; no ch0 flit appears mid-packet.
5. Backpressure: FIFO_DEPTH=4, out_rdy_i=0, ch3 offers 6 flits -> 5 accepted (1 output register + 4 FIFO), then in_rdy_o[3]=0; out_flit_o stays stable; after raising out_rdy_i all 6 exit in order with no loss or duplication.
6. Protocol error: PKT_MODE=1, BODY 32'h0000_00AA on ch0 in IDLE -> forwarded with err_o=1, which stays 1 until reset; same stimulus with PKT_MODE=0 -> err_o=0.
